aq_jpeg_bitpack: RTL

- Entropy-coded bitstream packer for the JPEG encoder path. It is the transmit-side counterpart of the decoder's register/unstuffing stage.
- Accepts variable-width Huffman/amplitude codes, concatenates them MSB-first and inserts a 0x00 after every 0xFF data byte (byte stuffing).
- Pads the final byte with 1s and emits 32-bit words with the first stream byte in DataOut[7:0].
- Sits between the Huffman encoder and the output AXI-stream/DMA writer.

---
 rtl/aq_jpeg_bitpack.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/aq_jpeg_bitpack.sv
// aq_jpeg_bitpack
// Bitstream packer for the JPEG entropy-coded segment. Right-aligned
// variable-width codes are concatenated MSB-first into a bit accumulator.
// Bytes are peeled off the top one per cycle, and a 0x00 is stuffed after
// every 0xFF data byte. The bytes are assembled LSB-byte-first into 32-bit
// words. On Flush, the last partial byte is padded with 1s, the pipeline is
// drained, and one terminating word is emitted with DataOutLast=1.
//
// Build option:
//   AQ_JPEG_BITPACK_EOI_EN - when defined, the EOI marker (FF D9, not stuffed)
//                            is appended after the drained data and before the
//                            terminating word.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   BitIn/BitWidth/BitEnable  code input, width 0..32 (33..63 clamp to 32)
//   BitReady                  a code can be accepted this cycle
//   Flush                     end of scan (honoured only in RUN)
//   DataOut/DataOutByteEn     packed word and byte enables, byte0 = [7:0]
//   DataOutEnable/Ready/Last  output handshake, Last marks the final word
//   Idle                      RUN state with nothing held anywhere
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_RUN   | accepting codes, streaming bytes
// S_PAD   | one cycle: append 1-bits up to the next byte boundary
// S_DRAIN | wait until accumulator, stuff and full assembler are empty
// S_EOI   | push FF D9 marker bytes (EOI build only)
// S_TERM  | emit the terminating word, wait for its handshake

module aq_jpeg_bitpack #(
   parameter int ACC_W    = 64,
   parameter int MAX_CODE = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] BitIn,
   input  logic [5:0]  BitWidth,
   input  logic        BitEnable,
   output logic        BitReady,
   input  logic        Flush,
   output logic [31:0] DataOut,
   output logic [3:0]  DataOutByteEn,
   output logic        DataOutEnable,
   input  logic        DataOutReady,
   output logic        DataOutLast,
   output logic        Idle
);

   localparam int FW = $clog2(ACC_W + 1);

   typedef enum logic [2:0] {
      S_RUN   = 3'd0,
      S_PAD   = 3'd1,
      S_DRAIN = 3'd2,
      S_EOI   = 3'd3,
      S_TERM  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [FW-1:0]      fill_q, fill_d;
   logic               stuff_q, stuff_d;
   logic [31:0]        asm_data_q, asm_data_d;
   logic [2:0]         asm_cnt_q, asm_cnt_d;
   logic [31:0]        out_data_q, out_data_d;
   logic [3:0]         out_be_q, out_be_d;
   logic               out_valid_q, out_valid_d;
   logic               out_last_q, out_last_d;
`ifdef AQ_JPEG_BITPACK_EOI_EN
   logic               eoi_idx_q, eoi_idx_d;
`endif

   logic               bit_ready;
   logic               accept;
   logic [5:0]         code_w;
   logic [2:0]         pad_w;
   logic [5:0]         app_w;
   logic [ACC_W-1:0]   app_bits;
   logic               out_free;
   logic               mv;
   logic               room;
   logic               push;
   logic               extract;
   logic [7:0]         push_byte;
   logic [7:0]         top_byte;
   logic [2:0]         base;
   logic               term_load;
   logic               eoi_push;
   logic [7:0]         eoi_byte;

   always_comb begin
      bit_ready = (state_q == S_RUN) && (fill_q <= FW'(ACC_W - MAX_CODE));
      accept    = BitEnable && bit_ready;
      code_w    = (BitWidth > 6'd32) ? 6'd32 : BitWidth;
      // (8 - fill mod 8) mod 8 is simply the 3-bit negation of fill[2:0]
      pad_w     = 3'd0 - fill_q[2:0];
      out_free  = !out_valid_q || DataOutReady;
      mv        = (asm_cnt_q == 3'd4) && out_free;
      // a full assembler that is moving out this cycle can take a new byte
      room      = (asm_cnt_q != 3'd4) || mv;
      top_byte  = 8'(acc_q >> (fill_q - FW'(8)));
      term_load = (state_q == S_TERM) && !out_last_q && (asm_cnt_q != 3'd4) && out_free;
`ifdef AQ_JPEG_BITPACK_EOI_EN
      eoi_push  = (state_q == S_EOI);
      eoi_byte  = eoi_idx_q ? 8'hD9 : 8'hFF;
`else
      eoi_push  = 1'b0;
      eoi_byte  = 8'h00;
`endif
   end

   // accumulator: new bits enter at the bottom, bytes leave from bit fill-1
   always_comb begin
      app_w    = 6'd0;
      app_bits = '0;
      if (accept) begin
         app_w    = code_w;
         app_bits = ACC_W'(BitIn) & ((ACC_W'(1) << code_w) - ACC_W'(1));
      end else if (state_q == S_PAD) begin
         app_w    = {3'b000, pad_w};
         app_bits = (ACC_W'(1) << pad_w) - ACC_W'(1);
      end
   end

   always_comb begin
      push      = 1'b0;
      extract   = 1'b0;
      push_byte = 8'h00;
      stuff_d   = stuff_q;
      if (room) begin
         if (eoi_push) begin
            // marker bytes bypass stuffing
            push      = 1'b1;
            push_byte = eoi_byte;
         end else if (stuff_q) begin
            push      = 1'b1;
            push_byte = 8'h00;
            stuff_d   = 1'b0;
         end else if (fill_q >= FW'(8)) begin
            push      = 1'b1;
            extract   = 1'b1;
            push_byte = top_byte;
            stuff_d   = (top_byte == 8'hFF);
         end
      end
      acc_d  = (acc_q << app_w) | app_bits;
      fill_d = fill_q - (extract ? FW'(8) : FW'(0)) + FW'(app_w);
   end

   always_comb begin
      base       = mv ? 3'd0 : asm_cnt_q;
      asm_data_d = mv ? 32'h0 : asm_data_q;
      asm_cnt_d  = base;
      if (push) begin
         case (base)
            3'd0:    asm_data_d[7:0]   = push_byte;
            3'd1:    asm_data_d[15:8]  = push_byte;
            3'd2:    asm_data_d[23:16] = push_byte;
            3'd3:    asm_data_d[31:24] = push_byte;
            default: asm_data_d        = asm_data_d;
         endcase
         asm_cnt_d = base + 3'd1;
      end
      if (term_load) begin
         asm_data_d = 32'h0;
         asm_cnt_d  = 3'd0;
      end
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_be_d    = out_be_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      if (out_valid_q && DataOutReady) begin
         out_data_d  = 32'h0;
         out_be_d    = 4'h0;
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
      if (mv) begin
         out_data_d  = asm_data_q;
         out_be_d    = 4'hF;
         out_valid_d = 1'b1;
         out_last_d  = 1'b0;
      end else if (term_load) begin
         out_data_d  = asm_data_q;
         out_valid_d = 1'b1;
         out_last_d  = 1'b1;
         case (asm_cnt_q)
            3'd1:    out_be_d = 4'b0001;
            3'd2:    out_be_d = 4'b0011;
            3'd3:    out_be_d = 4'b0111;
            default: out_be_d = 4'b0000;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
`ifdef AQ_JPEG_BITPACK_EOI_EN
      eoi_idx_d = eoi_idx_q;
`endif
      case (state_q)
         S_RUN:   if (Flush) state_d = S_PAD;
         S_PAD:   state_d = S_DRAIN;
         S_DRAIN: begin
            if ((fill_q == '0) && !stuff_q && (asm_cnt_q != 3'd4)) begin
`ifdef AQ_JPEG_BITPACK_EOI_EN
               state_d = S_EOI;
`else
               state_d = S_TERM;
`endif
            end
         end
`ifdef AQ_JPEG_BITPACK_EOI_EN
         S_EOI: begin
            if (push) begin
               eoi_idx_d = ~eoi_idx_q;
               if (eoi_idx_q) state_d = S_TERM;
            end
         end
`endif
         S_TERM:  if (out_valid_q && out_last_q && DataOutReady) state_d = S_RUN;
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_RUN;
         acc_q       <= '0;
         fill_q      <= '0;
         stuff_q     <= 1'b0;
         asm_data_q  <= 32'h0;
         asm_cnt_q   <= 3'd0;
         out_data_q  <= 32'h0;
         out_be_q    <= 4'h0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
`ifdef AQ_JPEG_BITPACK_EOI_EN
         eoi_idx_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         fill_q      <= fill_d;
         stuff_q     <= stuff_d;
         asm_data_q  <= asm_data_d;
         asm_cnt_q   <= asm_cnt_d;
         out_data_q  <= out_data_d;
         out_be_q    <= out_be_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
`ifdef AQ_JPEG_BITPACK_EOI_EN
         eoi_idx_q   <= eoi_idx_d;
`endif
      end
   end

   assign BitReady      = bit_ready;
   assign DataOut       = out_data_q;
   assign DataOutByteEn = out_be_q;
   assign DataOutEnable = out_valid_q;
   assign DataOutLast   = out_last_q;
   assign Idle          = (state_q == S_RUN) && (fill_q == '0) && !stuff_q &&
                          (asm_cnt_q == 3'd0) && !out_valid_q;

endmodule
